// File: rtl/output_io_arb_pkg.sv
// Shared types and constants for the OUTPUT_IO pad arbiter.
package output_io_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } state_e;

  localparam int TURN_W = 4;
  localparam int HOLD_W = 8;

  // Index width, kept at least 1 bit so single-bit ports never collapse.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/output_io_arb_rr_pick.sv
// Combinational round-robin picker: first set req bit at or above ptr, with wrap.
module rr_pick
  import output_io_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IW-1:0]   ptr_i,
  output logic            vld_o,
  output logic [IW-1:0]   idx_o
);

  assign vld_o = |req_i;

  // Scan offsets high to low so the smallest offset from ptr is the last write.
  always_comb begin
    idx_o = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % NREQ]) idx_o = IW'((int'(ptr_i) + i) % NREQ);
    end
  end

endmodule

// File: rtl/output_io_arb.sv
// Round-robin owner arbitration for one OUTPUT_IO pad with registered OQI data
// and a turnaround gap. Define OUTPUT_IO_ARB_TIMEOUT_EN for forced release after MAX_HOLD.
module output_io_arb
  import output_io_arb_pkg::*;
#(
  parameter int   NREQ     = 4,
  parameter int   TURN_CYC = 1,
  parameter int   MAX_HOLD = 16,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         dat,
  output logic [NREQ-1:0]         gnt,
  output logic [idx_w(NREQ)-1:0]  owner,
  output logic                    busy,
  output logic                    oqi
);

  localparam int IW = idx_w(NREQ);
  localparam logic [TURN_W-1:0] TURN_LD = (TURN_CYC > 0) ? TURN_W'(TURN_CYC - 1) : '0;

  if (NREQ < 2 || NREQ > 16 || TURN_CYC < 0 || TURN_CYC > 15 ||
      MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_cfg
    $error("output_io_arb: parameter out of range");
  end

  state_e            state_q;
  logic [NREQ-1:0]   gnt_q;
  logic [IW-1:0]     owner_q, ptr_q, ptr_d;
  logic [TURN_W-1:0] turn_q;
  logic              oqi_q;
  logic              pick_vld, tmo, rel;
  logic [IW-1:0]     pick_idx;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .vld_o (pick_vld),
    .idx_o (pick_idx)
  );

  assign ptr_d = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;

`ifdef OUTPUT_IO_ARB_TIMEOUT_EN
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);
  logic [HOLD_W-1:0] hold_q, hold_d;

  // gnt_q is the owner's one-hot in GRANT, so masking it leaves only waiters.
  assign tmo    = (|(req & ~gnt_q)) && (hold_q >= HOLD_LIM - 1'b1);
  assign hold_d = (state_q == IDLE) ? '0 :
                  (state_q == GRANT && hold_q != HOLD_LIM) ? hold_q + 1'b1 : hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  assign tmo = 1'b0;
`endif

  // A timeout coinciding with a req drop is just one release.
  assign rel = ~req[owner_q] | tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      turn_q  <= '0;
      oqi_q   <= IDLE_VAL;
    end else begin
      case (state_q)
        IDLE: begin
          oqi_q <= IDLE_VAL;
          if (pick_vld) begin
            gnt_q   <= NREQ'(1) << pick_idx;
            owner_q <= pick_idx;
            ptr_q   <= ptr_d;
            state_q <= GRANT;
          end
        end
        GRANT: begin
          if (rel) begin
            gnt_q   <= '0;
            oqi_q   <= IDLE_VAL;
            turn_q  <= TURN_LD;
            state_q <= (TURN_CYC > 0) ? TURN : IDLE;
          end else begin
            oqi_q <= dat[owner_q];
          end
        end
        TURN: begin
          oqi_q <= IDLE_VAL;
          if (turn_q == '0) state_q <= IDLE;
          else              turn_q  <= turn_q - 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt   = gnt_q;
  assign owner = owner_q;
  assign busy  = (state_q != IDLE);
  assign oqi   = oqi_q;

endmodule
